// File: rtl/if_pkg.sv
// Shared IF-stage constants, also imported by main control.
//   HALT_WORD / NOP_WORD     : special instruction words
//   PC_INCREMENT             : sequential PC step in bytes
//   NEXT_PC_SRC_SEQ/NOT_SEQ  : encoding of the next_pc_src select from ID
package if_pkg;

    typedef enum logic {
        NextPcSeq    = 1'b0,
        NextPcNotSeq = 1'b1
    } next_pc_src_e;

    localparam next_pc_src_e NEXT_PC_SRC_SEQ     = NextPcSeq;
    localparam next_pc_src_e NEXT_PC_SRC_NOT_SEQ = NextPcNotSeq;

    localparam logic [31:0] HALT_WORD    = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/instruction_memory.sv
// Loadable instruction memory for the IF stage.
// Synchronous write through an auto-incrementing write pointer, asynchronous read.
// Any word at or beyond the write pointer (including addresses past the array) reads
// as HALT, so an unloaded or overrun program stops fetch instead of wrapping.
// Ports:
//   i_clk, i_reset   : clock, asynchronous active-low reset (clears the pointer only)
//   i_wr, i_wr_data  : write strobe (already qualified by the caller) and word
//   i_clear          : synchronous pointer clear, wins over i_wr
//   i_rd_addr        : byte address; bits [1:0] ignored
//   o_rd_data        : fetched word or HALT
//   o_full, o_empty  : pointer == MEM_DEPTH / pointer == 0
module instruction_memory
    import if_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [IDX_W:0] DepthCount = (IDX_W + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    // One extra bit so the full state is representable.
    logic [IDX_W:0]        wr_ptr_q, wr_ptr_d;
    logic                  wr_accept;

    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;
    logic                  unused_addr_lsb;

    assign o_full    = (wr_ptr_q == DepthCount);
    assign o_empty   = (wr_ptr_q == '0);
    assign wr_accept = i_wr & ~o_full & ~i_clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (i_clear) begin
            wr_ptr_d = '0;
        end else if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + (IDX_W + 1)'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Contents survive reset and clear; only the pointer decides what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= i_wr_data;
        end
    end

    assign rd_idx          = i_rd_addr[IDX_W+1:2];
    assign unused_addr_lsb = ^i_rd_addr[1:0];
    // Upper address bits must be zero: addresses past the array never alias.
    assign rd_in_range     = (i_rd_addr[ADDR_WIDTH-1:IDX_W+2] == '0) &&
                             ({1'b0, rd_idx} < wr_ptr_q);
    assign o_rd_data       = rd_in_range ? mem_q[rd_idx] : DATA_WIDTH'(HALT_WORD);

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline.
// Holds the PC, selects the next PC (sequential or the ID-resolved target), registers the
// IF/ID latch (instruction, PC+4) and freezes fetch once a HALT word is latched.
// Optional build macro IF_FLUSH_ON_JUMP_EN: when defined, a redirect replaces the word
// fetched alongside it with a NOP (no delay slot); when undefined the delay slot executes.
// Ports:
//   i_clk, i_reset     : clock, asynchronous active-low reset
//   i_enable, i_stall  : pipeline advance / hazard hold
//   i_next_pc_src      : 0 sequential, 1 take i_jmp_addr
//   i_jmp_addr         : byte target from ID
//   i_ins_wr, i_ins_wr_data, i_ins_clear : program loader
//   o_instruction, o_next_seq_pc         : IF/ID latch
//   o_pc               : current fetch PC
//   o_halt             : HALT latched, fetch frozen
//   o_mem_full, o_mem_empty              : loader pointer status
module instruction_fetch
    import if_pkg::*;
#(
    parameter int unsigned PC_BUS_SIZE          = 32,
    parameter int unsigned INSTRUCTION_BUS_SIZE = 32,
    parameter int unsigned MEM_DEPTH            = 64
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic                            i_stall,
    input  logic                            i_next_pc_src,
    input  logic [PC_BUS_SIZE-1:0]          i_jmp_addr,
    input  logic                            i_ins_wr,
    input  logic [INSTRUCTION_BUS_SIZE-1:0] i_ins_wr_data,
    input  logic                            i_ins_clear,
    output logic [INSTRUCTION_BUS_SIZE-1:0] o_instruction,
    output logic [PC_BUS_SIZE-1:0]          o_next_seq_pc,
    output logic [PC_BUS_SIZE-1:0]          o_pc,
    output logic                            o_halt,
    output logic                            o_mem_full,
    output logic                            o_mem_empty
);

    localparam logic [INSTRUCTION_BUS_SIZE-1:0] HaltWord = INSTRUCTION_BUS_SIZE'(HALT_WORD);
    localparam logic [INSTRUCTION_BUS_SIZE-1:0] NopWord  = INSTRUCTION_BUS_SIZE'(NOP_WORD);
    localparam logic [PC_BUS_SIZE-1:0]          PcStep   = PC_BUS_SIZE'(PC_INCREMENT);

    logic [PC_BUS_SIZE-1:0]          pc_q, pc_d;
    logic [PC_BUS_SIZE-1:0]          seq_pc_q, seq_pc_d;
    logic [INSTRUCTION_BUS_SIZE-1:0] instr_q, instr_d;
    logic                            halt_q, halt_d;

    logic [PC_BUS_SIZE-1:0]          pc_plus4;
    logic [INSTRUCTION_BUS_SIZE-1:0] fetch_word;
    logic                            adv;
    logic                            redirect;

    instruction_memory #(
        .ADDR_WIDTH (PC_BUS_SIZE),
        .DATA_WIDTH (INSTRUCTION_BUS_SIZE),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_imem (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr      (i_ins_wr & ~i_enable),
        .i_wr_data (i_ins_wr_data),
        .i_clear   (i_ins_clear),
        .i_rd_addr (pc_q),
        .o_rd_data (fetch_word),
        .o_full    (o_mem_full),
        .o_empty   (o_mem_empty)
    );

    assign adv      = i_enable & ~i_stall & ~halt_q;
    assign pc_plus4 = pc_q + PcStep;
    assign redirect = (i_next_pc_src == NEXT_PC_SRC_NOT_SEQ);

    always_comb begin
        pc_d     = pc_q;
        seq_pc_d = seq_pc_q;
        instr_d  = instr_q;
        halt_d   = halt_q;
        if (i_ins_clear) begin
            pc_d     = '0;
            seq_pc_d = '0;
            instr_d  = NopWord;
            halt_d   = 1'b0;
        end else if (adv) begin
            seq_pc_d = pc_plus4;
            pc_d     = redirect ? i_jmp_addr : pc_plus4;
`ifdef IF_FLUSH_ON_JUMP_EN
            if (redirect) begin
                // Squashed word never executes, so it cannot halt either.
                instr_d = NopWord;
            end else begin
                instr_d = fetch_word;
                halt_d  = (fetch_word == HaltWord);
            end
`else
            // The word fetched alongside a redirect is the delay slot and is kept.
            instr_d = fetch_word;
            halt_d  = (fetch_word == HaltWord);
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q     <= '0;
            seq_pc_q <= '0;
            instr_q  <= NopWord;
            halt_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            seq_pc_q <= seq_pc_d;
            instr_q  <= instr_d;
            halt_q   <= halt_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_next_seq_pc = seq_pc_q;
    assign o_instruction = instr_q;
    assign o_halt        = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed stimulus, a word-level reference model updated on
// every clock, a per-cycle compare on the falling edge and hand-computed literal checks.
module tb_instruction_fetch;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
`ifdef IF_FLUSH_ON_JUMP_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, stall, next_pc_src, ins_wr, ins_clear;
    logic [31:0] jmp_addr, ins_wr_data;
    logic [31:0] instruction, next_seq_pc, pc;
    logic        halt, mem_full, mem_empty;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .PC_BUS_SIZE          (32),
        .INSTRUCTION_BUS_SIZE (32),
        .MEM_DEPTH            (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_enable      (enable),
        .i_stall       (stall),
        .i_next_pc_src (next_pc_src),
        .i_jmp_addr    (jmp_addr),
        .i_ins_wr      (ins_wr),
        .i_ins_wr_data (ins_wr_data),
        .i_ins_clear   (ins_clear),
        .o_instruction (instruction),
        .o_next_seq_pc (next_seq_pc),
        .o_pc          (pc),
        .o_halt        (halt),
        .o_mem_full    (mem_full),
        .o_mem_empty   (mem_empty)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_ptr, m_pc, m_nseq, m_instr;
    logic        m_halt;

    // A word is valid only if its index lies below the number of words loaded.
    function automatic logic [31:0] m_fetch(input logic [31:0] addr);
        if ((addr >> 2) < m_ptr) return m_mem[addr >> 2];
        return HALT;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   <= 0;
            m_pc    <= 0;
            m_nseq  <= 0;
            m_instr <= 0;
            m_halt  <= 1'b0;
        end else if (ins_clear) begin
            m_ptr   <= 0;
            m_pc    <= 0;
            m_nseq  <= 0;
            m_instr <= 0;
            m_halt  <= 1'b0;
        end else begin
            if (!enable && ins_wr && m_ptr < DEPTH) begin
                m_mem[m_ptr] <= ins_wr_data;
                m_ptr        <= m_ptr + 1;
            end
            if (enable && !stall && !m_halt) begin
                m_nseq <= m_pc + 4;
                m_pc   <= next_pc_src ? jmp_addr : m_pc + 4;
                if (FLUSH && next_pc_src) begin
                    m_instr <= 0;
                end else begin
                    m_instr <= m_fetch(m_pc);
                    m_halt  <= (m_fetch(m_pc) == HALT);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_pc", pc, m_pc);
            check("cmp_instruction", instruction, m_instr);
            check("cmp_next_seq_pc", next_seq_pc, m_nseq);
            check("cmp_halt", {31'b0, halt}, {31'b0, m_halt});
            check("cmp_mem_full", {31'b0, mem_full}, {31'b0, (m_ptr == DEPTH)});
            check("cmp_mem_empty", {31'b0, mem_empty}, {31'b0, (m_ptr == 0)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] word);
        ins_wr      = 1'b1;
        ins_wr_data = word;
        step();
        ins_wr      = 1'b0;
    endtask

    task automatic do_clear();
        ins_clear = 1'b1;
        step();
        ins_clear = 1'b0;
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h2001_0005;
        prog[1] = 32'h2002_0007;
        prog[2] = 32'h0022_1820;
        prog[3] = 32'hFFFF_FFFF;

        rst_n = 1'b0; enable = 1'b0; stall = 1'b0; next_pc_src = 1'b0;
        jmp_addr = '0; ins_wr = 1'b0; ins_wr_data = '0; ins_clear = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_next_seq_pc", next_seq_pc, 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h0);
        check("rst_empty", {31'b0, mem_empty}, 32'h1);
        check("rst_full", {31'b0, mem_full}, 32'h0);
        step();
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Basic program run ending on HALT.
        for (int i = 0; i < 4; i++) load(prog[i]);
        check("load_empty", {31'b0, mem_empty}, 32'h0);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("run_instruction", instruction, prog[k]);
            check("run_pc", pc, 32'(4 * (k + 1)));
        end
        check("run_halt", {31'b0, halt}, 32'h1);
        step();
        step();
        check("halt_pc_frozen", pc, 32'h10);
        check("halt_instr_held", instruction, HALT);
        enable = 1'b0;

        // Redirect with delay slot.
        do_clear();
        check("clr_pc", pc, 32'h0);
        check("clr_halt", {31'b0, halt}, 32'h0);
        check("clr_empty", {31'b0, mem_empty}, 32'h1);
        for (int i = 0; i < 12; i++) load(32'h1000_0000 + 32'(i));
        enable = 1'b1;
        step();
        step();
        check("pre_jump_pc", pc, 32'h8);
        next_pc_src = 1'b1; jmp_addr = 32'h20;
        step();
        next_pc_src = 1'b0;
        check("jump_pc", pc, 32'h20);
        check("delay_slot", instruction, FLUSH ? 32'h0 : 32'h1000_0002);
        check("jump_next_seq", next_seq_pc, 32'hC);
        step();
        check("target_instr", instruction, 32'h1000_0008);
        check("target_pc", pc, 32'h24);

        // Stall at PC=4 with a pending redirect.
        next_pc_src = 1'b1; jmp_addr = 32'h4;
        step();
        jmp_addr = 32'h30; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("stall_pc", pc, 32'h4);
            check("stall_instr", instruction, FLUSH ? 32'h0 : 32'h1000_0009);
            check("stall_next_seq", next_seq_pc, 32'h28);
            step();
        end
        check("stall_end_pc", pc, 32'h4);
        stall = 1'b0; next_pc_src = 1'b0;
        step();
        check("unstall_pc", pc, 32'h8);
        check("unstall_instr", instruction, 32'h1000_0001);
        enable = 1'b0;

        // Fill memory, drop the overflow write, run off the end.
        do_clear();
        for (int i = 0; i < 64; i++) load(32'hA500_0000 + 32'(i));
        check("full_set", {31'b0, mem_full}, 32'h1);
        load(32'hDEAD_BEEF);
        check("full_hold", {31'b0, mem_full}, 32'h1);
        enable = 1'b1;
        step();
        check("full_word0", instruction, 32'hA500_0000);
        next_pc_src = 1'b1; jmp_addr = 32'hFC;
        step();
        next_pc_src = 1'b0;
        check("last_pc", pc, 32'hFC);
        step();
        check("last_word", instruction, 32'hA500_003F);
        check("last_no_halt", {31'b0, halt}, 32'h0);
        step();
        check("past_end_halt", instruction, HALT);
        check("past_end_halt_flag", {31'b0, halt}, 32'h1);
        check("past_end_pc", pc, 32'h104);
        enable = 1'b0;

        // Writes while enabled are dropped; empty memory halts immediately.
        do_clear();
        check("clr2_halt", {31'b0, halt}, 32'h0);
        check("clr2_pc", pc, 32'h0);
        enable = 1'b1; stall = 1'b1;
        load(32'h1234_5678);
        check("wr_enabled_dropped", {31'b0, mem_empty}, 32'h1);
        stall = 1'b0;
        step();
        check("empty_halt_instr", instruction, HALT);
        check("empty_halt_flag", {31'b0, halt}, 32'h1);
        check("empty_halt_pc", pc, 32'h4);
        enable = 1'b0;

        // Jump beyond the array reads HALT.
        do_clear();
        load(32'h2400_0001);
        load(32'h2400_0002);
        enable = 1'b1;
        next_pc_src = 1'b1; jmp_addr = 32'h400;
        step();
        next_pc_src = 1'b0;
        check("far_jump_pc", pc, 32'h400);
        check("far_delay_slot", instruction, FLUSH ? 32'h0 : 32'h2400_0001);
        step();
        check("far_halt", instruction, HALT);
        check("far_halt_flag", {31'b0, halt}, 32'h1);
        enable = 1'b0;

        // Asynchronous reset mid-run.
        do_clear();
        for (int i = 0; i < 8; i++) load(32'h3000_0000 + 32'(i));
        enable = 1'b1;
        repeat (4) step();
        check("mid_pc", pc, 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_instr", instruction, 32'h0);
        check("async_halt", {31'b0, halt}, 32'h0);
        check("async_empty", {31'b0, mem_empty}, 32'h1);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_halt", instruction, HALT);
        check("post_rst_halt_flag", {31'b0, halt}, 32'h1);
        enable = 1'b0;
        step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
